// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the fpga_core_2x2 configuration sequencer.
//   cfg_state_t    sequencer state encoding
//   CLB_BITS_2X2   CLB scan chain length of the 2x2 core
//   CONN_BITS_2X2  connection scan chain length of the 2x2 core
//   words_for()    number of W-bit stream words needed to fill a chain
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CLB,
    S_GAP1,
    S_LOAD_CONN,
    S_GAP2,
    S_RST,
    S_DONE
  } cfg_state_t;

  localparam int CLB_BITS_2X2  = 116;
  localparam int CONN_BITS_2X2 = 432;

  function automatic int words_for(input int bits, input int w);
    return (bits + w - 1) / w;
  endfunction

endpackage

// File: rtl/fpga_config_ctrl_if.sv
// Bitstream word stream (valid/ready).
//   bs_data   W-bit bitstream word
//   bs_valid  bs_data valid
//   bs_ready  word accepted when bs_valid && bs_ready
// master = bitstream source, slave = configuration controller.
interface fpga_config_ctrl_if #(
  parameter int W = 8
);
  logic [W-1:0] bs_data;
  logic         bs_valid;
  logic         bs_ready;

  modport master (output bs_data, output bs_valid, input bs_ready);
  modport slave  (input bs_data, input bs_valid, output bs_ready);
endinterface

// File: rtl/cfg_word_serializer.sv
// Word-to-bit serializer for the configuration stream.
//   clk, reset_n  controller clock, async active-low reset
//   enable        a load phase is active; bs_ready is held low otherwise
//   advance       the current bit is consumed this cycle
//   flush         phase end: drop any bits left in the current word
//   refill_ok     a new word may be taken while the last bit is consumed
//   bs            bitstream stream (slave side)
//   ser_bit       current bit (LSB of the remaining word)
//   ser_bit_valid a bit is available
module cfg_word_serializer #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                advance,
  input  logic                flush,
  input  logic                refill_ok,
  fpga_config_ctrl_if.slave   bs,
  output logic                ser_bit,
  output logic                ser_bit_valid
);
  localparam int IW = $clog2(W + 1);

  logic [W-1:0]  shreg;
  logic [IW-1:0] bits_left;
  logic          accept;

  assign ser_bit_valid = (bits_left != '0);
  assign ser_bit       = shreg[0];

  // Taking a word while the last bit leaves gives gapless back-to-back words.
  assign bs.bs_ready = enable &&
                       ((bits_left == '0) ||
                        ((bits_left == IW'(1)) && advance && refill_ok));
  assign accept = bs.bs_valid && bs.bs_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      bits_left <= '0;
    end else if (accept) begin
      // A word taken on the final bit of a phase belongs to the next phase.
      shreg     <= bs.bs_data;
      bits_left <= IW'(W);
    end else if (flush) begin
      bits_left <= '0;
    end else if (advance) begin
      shreg     <= shreg >> 1;
      bits_left <= bits_left - 1'b1;
    end
  end

endmodule

// File: rtl/fpga_config_ctrl.sv
// Configuration sequencer for fpga_core_2x2: serialises the bitstream into
// the CLB chain, then the connection chain, then enables the fabric clock
// and issues a timed fabric reset.
//   clk            controller clock (also the core scan clock)
//   reset_n        async active-low reset
//   start          begin configuration (honoured in IDLE/DONE only)
//   bs             bitstream stream (slave side)
//   clb_scan_in/en CLB chain data / shift enable
//   conn_scan_in/en connection chain data / shift enable
//   fpga_clk_en    fabric clock gate
//   fpga_reset     active-high fabric reset
//   busy, done     status
//
// state       | meaning
// ------------+---------------------------------------------
// S_IDLE      | after reset, waiting for start
// S_LOAD_CLB  | shifting CLB_BITS bits into the CLB chain
// S_GAP1      | GAP_CYCLES with both enables low
// S_LOAD_CONN | shifting CONN_BITS bits into the connection chain
// S_GAP2      | GAP_CYCLES with both enables low
// S_RST       | fabric clock on, fabric reset for RST_CYCLES
// S_DONE      | configured, waiting for a restart
module fpga_config_ctrl
  import fpga_cfg_pkg::*;
#(
  parameter int W          = 8,
  parameter int CLB_BITS   = CLB_BITS_2X2,
  parameter int CONN_BITS  = CONN_BITS_2X2,
  parameter int RST_CYCLES = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  fpga_config_ctrl_if.slave bs,
  output logic              clb_scan_in,
  output logic              clb_scan_en,
  output logic              conn_scan_in,
  output logic              conn_scan_en,
  output logic              fpga_clk_en,
  output logic              fpga_reset,
  output logic              busy,
  output logic              done
);
  localparam int MAX_BITS = (CLB_BITS > CONN_BITS) ? CLB_BITS : CONN_BITS;
  localparam int CW = $clog2(MAX_BITS + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  cfg_state_t    state;
  logic [CW-1:0] chain_cnt;
  logic [RW-1:0] rst_cnt;
  logic [GW-1:0] gap_cnt;

  logic in_load;
  logic chain_last;
  logic advance;
  logic refill_ok;
  logic ser_bit;
  logic ser_bit_valid;

  assign in_load    = (state == S_LOAD_CLB) || (state == S_LOAD_CONN);
  assign chain_last = (state == S_LOAD_CLB) ? (chain_cnt == CW'(CLB_BITS - 1))
                                            : (chain_cnt == CW'(CONN_BITS - 1));
  assign advance    = in_load && ser_bit_valid;
  // Prefetch across the CLB->CONN boundary only; after the last connection
  // bit nothing more may be pulled from the stream.
  assign refill_ok  = (state == S_LOAD_CLB) || !chain_last;

  cfg_word_serializer #(.W(W)) u_ser (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (in_load),
    .advance       (advance),
    .flush         (advance && chain_last),
    .refill_ok     (refill_ok),
    .bs            (bs),
    .ser_bit       (ser_bit),
    .ser_bit_valid (ser_bit_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      chain_cnt    <= '0;
      rst_cnt      <= '0;
      gap_cnt      <= '0;
      clb_scan_in  <= 1'b0;
      clb_scan_en  <= 1'b0;
      conn_scan_in <= 1'b0;
      conn_scan_en <= 1'b0;
      fpga_clk_en  <= 1'b0;
      fpga_reset   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_LOAD_CLB;
            chain_cnt   <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            fpga_clk_en <= 1'b0;
          end
        end
        S_LOAD_CLB: begin
          // Underflow stalls the chain; scan_in keeps its last value.
          if (ser_bit_valid) begin
            clb_scan_en <= 1'b1;
            clb_scan_in <= ser_bit;
            if (chain_last) begin
              state     <= S_GAP1;
              chain_cnt <= '0;
              gap_cnt   <= GW'(GAP_CYCLES);
            end else begin
              chain_cnt <= chain_cnt + 1'b1;
            end
          end else begin
            clb_scan_en <= 1'b0;
          end
        end
        S_GAP1: begin
          clb_scan_en <= 1'b0;
          if (gap_cnt == GW'(1)) begin
            state <= S_LOAD_CONN;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_LOAD_CONN: begin
          if (ser_bit_valid) begin
            conn_scan_en <= 1'b1;
            conn_scan_in <= ser_bit;
            if (chain_last) begin
              state     <= S_GAP2;
              chain_cnt <= '0;
              gap_cnt   <= GW'(GAP_CYCLES);
            end else begin
              chain_cnt <= chain_cnt + 1'b1;
            end
          end else begin
            conn_scan_en <= 1'b0;
          end
        end
        S_GAP2: begin
          conn_scan_en <= 1'b0;
          if (gap_cnt == GW'(1)) begin
            state       <= S_RST;
            fpga_clk_en <= 1'b1;
            fpga_reset  <= 1'b1;
            rst_cnt     <= RW'(RST_CYCLES);
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_RST: begin
          if (rst_cnt == RW'(1)) begin
            state      <= S_DONE;
            fpga_reset <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_config_ctrl.sv
module tb_fpga_config_ctrl;
  import fpga_cfg_pkg::*;

  // Instance 0: small chains (16/8); instance 1: 2x2 core defaults.
  localparam int S_CLB  = 16;
  localparam int S_CONN = 8;
  localparam int D_CLB  = CLB_BITS_2X2;
  localparam int D_CONN = CONN_BITS_2X2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] start_v;
  logic [1:0] valid_v;
  logic [7:0] data_v [2];
  logic [1:0] rdy, clb_in, clb_en, conn_in, conn_en, clk_en, frst, busy, done;

  fpga_config_ctrl_if #(.W(8)) bif_s ();
  fpga_config_ctrl_if #(.W(8)) bif_d ();

  assign bif_s.bs_valid = valid_v[0];
  assign bif_s.bs_data  = data_v[0];
  assign rdy[0]         = bif_s.bs_ready;
  assign bif_d.bs_valid = valid_v[1];
  assign bif_d.bs_data  = data_v[1];
  assign rdy[1]         = bif_d.bs_ready;

  fpga_config_ctrl #(.W(8), .CLB_BITS(S_CLB), .CONN_BITS(S_CONN),
                     .RST_CYCLES(2), .GAP_CYCLES(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .bs(bif_s),
    .clb_scan_in(clb_in[0]), .clb_scan_en(clb_en[0]),
    .conn_scan_in(conn_in[0]), .conn_scan_en(conn_en[0]),
    .fpga_clk_en(clk_en[0]), .fpga_reset(frst[0]),
    .busy(busy[0]), .done(done[0])
  );

  fpga_config_ctrl #(.W(8), .CLB_BITS(D_CLB), .CONN_BITS(D_CONN),
                     .RST_CYCLES(2), .GAP_CYCLES(1)) dut_d (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .bs(bif_d),
    .clb_scan_in(clb_in[1]), .clb_scan_en(clb_en[1]),
    .conn_scan_in(conn_in[1]), .conn_scan_en(conn_en[1]),
    .fpga_clk_en(clk_en[1]), .fpga_reset(frst[1]),
    .busy(busy[1]), .done(done[1])
  );

  always #5 clk = ~clk;

  int total;
  int bad;

  logic [7:0] words [0:127];
  int         nwords;

  // Per-run observation record (what each chain received, in shift order).
  logic clb_rec  [0:511];
  logic conn_rec [0:511];
  int   clb_n, conn_n, clb_hole, gap_n, rst_hi, rst_noclk, early_rst;
  int   overlap, busy_err, accepted;
  bit   got_done;

  // Feeds the stream to instance w and records both chains until done,
  // the cycle budget runs out, or reset is pulled at connection bit abort_bit.
  task automatic run_cfg(input int w, input int clb_t, input int conn_t,
                         input bit do_start, input int stall_word,
                         input int stall_len, input int start2_cyc,
                         input int abort_bit, input int budget);
    int   stalls;
    logic rdy_s;
    clb_n = 0; conn_n = 0; clb_hole = 0; gap_n = 0; rst_hi = 0;
    rst_noclk = 0; early_rst = 0; overlap = 0; busy_err = 0;
    accepted = 0; got_done = 1'b0; stalls = 0;
    if (do_start) begin
      start_v[w] = 1'b1;
      @(posedge clk); #1;
      start_v[w] = 1'b0;
    end
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (rdy[w] && accepted == stall_word && stalls < stall_len) begin
        valid_v[w] = 1'b0;
        stalls++;
      end else begin
        valid_v[w] = (accepted < nwords);
      end
      data_v[w]  = (accepted < 128) ? words[accepted] : 8'h00;
      start_v[w] = (cyc == start2_cyc);
      @(negedge clk);
      if (clb_en[w]) begin
        clb_rec[clb_n] = clb_in[w];
        clb_n++;
      end else if (clb_n > 0 && clb_n < clb_t) begin
        clb_hole++;
      end
      if (conn_en[w]) begin
        conn_rec[conn_n] = conn_in[w];
        conn_n++;
      end
      if (!clb_en[w] && !conn_en[w] && clb_n == clb_t && conn_n == 0) gap_n++;
      if (clb_en[w] && conn_en[w]) overlap++;
      if (frst[w]) begin
        rst_hi++;
        if (!clk_en[w]) rst_noclk++;
        if (conn_n != conn_t) early_rst++;
      end
      if (busy[w] === done[w]) busy_err++;
      rdy_s = rdy[w];
      if (done[w]) begin
        got_done = 1'b1;
        break;
      end
      if (abort_bit > 0 && conn_n == abort_bit) begin
        reset_n    = 1'b0;
        valid_v[w] = 1'b0;
        start_v[w] = 1'b0;
        return;
      end
      @(posedge clk);
      if (valid_v[w] && rdy_s) accepted++;
      #1;
    end
    valid_v[w] = 1'b0;
    start_v[w] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_small_words();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00;
    nwords = 4;
  endtask

  task automatic load_default_words();
    for (int i = 0; i < 128; i++) words[i] = 8'((i * 37 + 11) & 255);
    nwords = 75;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    valid_v = 2'b11;
    #1;
    for (int w = 0; w < 2; w++) begin
      total++;
      if ({clb_in[w], clb_en[w], conn_in[w], conn_en[w], clk_en[w], frst[w],
           busy[w], done[w]} !== 8'h00) begin
        bad++;
        $display("FAIL reset_outputs[%0d]: got %b want 00000000", w,
                 {clb_in[w], clb_en[w], conn_in[w], conn_en[w], clk_en[w],
                  frst[w], busy[w], done[w]});
      end
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rdy !== 2'b00) begin
      bad++;
      $display("FAIL idle_ready: got %b want 00", rdy);
    end
    total++;
    if (dut_d.state !== S_IDLE) begin
      bad++;
      $display("FAIL idle_state: got %0d want %0d", dut_d.state, S_IDLE);
    end
    valid_v = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] clb_obs;
    logic [7:0]  conn_obs;
    load_small_words();
    run_cfg(0, S_CLB, S_CONN, 1'b1, -1, 0, -1, 0, 200);
    clb_obs = '0; conn_obs = '0;
    for (int i = 0; i < 16; i++) clb_obs[i] = clb_rec[i];
    for (int i = 0; i < 8; i++) conn_obs[i] = conn_rec[i];
    total++;
    if (!got_done) begin bad++; $display("FAIL basic_done: got 0 want 1"); end
    total++;
    if (clb_n != 16) begin bad++; $display("FAIL basic_clb_n: got %0d want 16", clb_n); end
    total++;
    if (clb_obs !== 16'h3CA5) begin
      bad++; $display("FAIL basic_clb_seq: got %h want 3ca5", clb_obs);
    end
    total++;
    if (clb_hole != 0) begin bad++; $display("FAIL basic_clb_hole: got %0d want 0", clb_hole); end
    total++;
    if (gap_n != 1) begin bad++; $display("FAIL basic_gap: got %0d want 1", gap_n); end
    total++;
    if (conn_n != 8 || conn_obs !== 8'hFF) begin
      bad++; $display("FAIL basic_conn: got n=%0d %h want n=8 ff", conn_n, conn_obs);
    end
    total++;
    if (rst_hi != 2 || rst_noclk != 0 || early_rst != 0) begin
      bad++;
      $display("FAIL basic_rst_pulse: got hi=%0d noclk=%0d early=%0d want 2 0 0",
               rst_hi, rst_noclk, early_rst);
    end
    total++;
    if (overlap != 0 || busy_err != 0) begin
      bad++; $display("FAIL basic_flags: got overlap=%0d busy_err=%0d want 0 0", overlap, busy_err);
    end
    total++;
    if (accepted != 3) begin bad++; $display("FAIL basic_words: got %0d want 3", accepted); end
    total++;
    if ({done[0], clk_en[0], frst[0], busy[0]} !== 4'b1100) begin
      bad++;
      $display("FAIL basic_final: got %b want 1100", {done[0], clk_en[0], frst[0], busy[0]});
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] clb_obs;
    load_small_words();
    run_cfg(0, S_CLB, S_CONN, 1'b1, -1, 0, 5, 0, 200);
    clb_obs = '0;
    for (int i = 0; i < 16; i++) clb_obs[i] = clb_rec[i];
    total++;
    if (!got_done || accepted != 3 || clb_n != 16 || clb_obs !== 16'h3CA5) begin
      bad++;
      $display("FAIL start_ignored: got done=%0d words=%0d n=%0d %h want 1 3 16 3ca5",
               got_done, accepted, clb_n, clb_obs);
    end
  endtask

  task automatic test_restart_from_done();
    logic [7:0] conn_obs;
    load_small_words();
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(negedge clk);
    total++;
    if ({done[0], clk_en[0], busy[0]} !== 3'b001) begin
      bad++;
      $display("FAIL restart_clear: got done,clk_en,busy=%b want 001",
               {done[0], clk_en[0], busy[0]});
    end
    @(posedge clk); #1;
    run_cfg(0, S_CLB, S_CONN, 1'b0, -1, 0, -1, 0, 200);
    conn_obs = '0;
    for (int i = 0; i < 8; i++) conn_obs[i] = conn_rec[i];
    total++;
    if (!got_done || clb_n != 16 || conn_obs !== 8'hFF) begin
      bad++;
      $display("FAIL restart_reload: got done=%0d clb_n=%0d conn=%h want 1 16 ff",
               got_done, clb_n, conn_obs);
    end
  endtask

  task automatic test_underflow();
    int clb_bad, conn_bad;
    load_default_words();
    run_cfg(1, D_CLB, D_CONN, 1'b1, 3, 5, -1, 0, 1500);
    clb_bad = 0; conn_bad = 0;
    for (int k = 0; k < D_CLB; k++)
      if (clb_rec[k] !== words[k / 8][k % 8]) clb_bad++;
    for (int j = 0; j < D_CONN; j++)
      if (conn_rec[j] !== words[words_for(D_CLB, 8) + j / 8][j % 8]) conn_bad++;
    total++;
    if (!got_done) begin bad++; $display("FAIL uf_done: got 0 want 1"); end
    total++;
    if (clb_hole != 5) begin bad++; $display("FAIL uf_stall: got %0d want 5", clb_hole); end
    total++;
    if (clb_n != D_CLB) begin bad++; $display("FAIL uf_clb_n: got %0d want %0d", clb_n, D_CLB); end
    total++;
    if (clb_bad != 0) begin bad++; $display("FAIL uf_clb_bits: got %0d wrong want 0", clb_bad); end
    total++;
    if (conn_n != D_CONN || conn_bad != 0) begin
      bad++; $display("FAIL uf_conn: got n=%0d wrong=%0d want %0d 0", conn_n, conn_bad, D_CONN);
    end
    total++;
    if (accepted != words_for(D_CLB, 8) + words_for(D_CONN, 8)) begin
      bad++; $display("FAIL uf_words: got %0d want 69", accepted);
    end
  endtask

  task automatic test_partial_word();
    logic [3:0] tail;
    logic [7:0] conn_head;
    load_default_words();
    run_cfg(1, D_CLB, D_CONN, 1'b1, -1, 0, -1, 0, 1500);
    for (int i = 0; i < 4; i++) tail[i] = clb_rec[112 + i];
    for (int i = 0; i < 8; i++) conn_head[i] = conn_rec[i];
    total++;
    if (tail !== words[14][3:0]) begin
      bad++; $display("FAIL partial_tail: got %h want %h", tail, words[14][3:0]);
    end
    total++;
    if (conn_head !== words[15]) begin
      bad++; $display("FAIL partial_conn_head: got %h want %h", conn_head, words[15]);
    end
    total++;
    if (!got_done || rst_hi != 2 || overlap != 0 || busy_err != 0) begin
      bad++;
      $display("FAIL partial_flags: got done=%0d rst=%0d ovl=%0d busy_err=%0d want 1 2 0 0",
               got_done, rst_hi, overlap, busy_err);
    end
  endtask

  task automatic test_reset_mid_conn();
    int conn_bad;
    load_default_words();
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    run_cfg(1, D_CLB, D_CONN, 1'b0, -1, 0, -1, 200, 1500);
    #1;
    total++;
    if (reset_n !== 1'b0) begin
      bad++; $display("FAIL mid_reset_reached: got conn_n=%0d want 200", conn_n);
    end
    total++;
    if ({clb_in[1], clb_en[1], conn_in[1], conn_en[1], clk_en[1], frst[1],
         busy[1], done[1], rdy[1]} !== 9'h000) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %b want 000000000",
               {clb_in[1], clb_en[1], conn_in[1], conn_en[1], clk_en[1], frst[1],
                busy[1], done[1], rdy[1]});
    end
    total++;
    if (dut_d.state !== S_IDLE) begin
      bad++; $display("FAIL mid_reset_state: got %0d want %0d", dut_d.state, S_IDLE);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    run_cfg(1, D_CLB, D_CONN, 1'b1, -1, 0, -1, 0, 1500);
    conn_bad = 0;
    for (int j = 0; j < D_CONN; j++)
      if (conn_rec[j] !== words[15 + j / 8][j % 8]) conn_bad++;
    total++;
    if (!got_done || clb_n != D_CLB || conn_n != D_CONN || conn_bad != 0) begin
      bad++;
      $display("FAIL mid_reset_reload: got done=%0d clb=%0d conn=%0d wrong=%0d want 1 %0d %0d 0",
               got_done, clb_n, conn_n, conn_bad, D_CLB, D_CONN);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    start_v = 2'b00;
    valid_v = 2'b00;
    data_v[0] = 8'h00;
    data_v[1] = 8'h00;
    nwords = 0;
    test_reset();
    test_basic();
    test_start_ignored();
    test_restart_from_done();
    test_underflow();
    test_partial_word();
    test_reset_mid_conn();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
